// File: rtl/pwm_ctrl_pkg.sv
// Shared types and duty arithmetic for the PWM duty sequencer.
// Duty values are signed two's complement of the PWM generator's width.
package pwm_ctrl_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        UPDATE = 1'b1
    } state_t;

    // 0% duty: a signed compare "duty > cnt" is never true at this value.
    function automatic int min_duty(input int dw);
        return -(1 << (dw - 1));
    endfunction

    function automatic int max_duty(input int dw);
        return (1 << (dw - 1)) - 1;
    endfunction

    // Moves duty toward eff by at most step and never overshoots.
    // The int difference is wider than DW+1 bits, so it cannot overflow,
    // and the result always lies between duty and eff.
    function automatic int slew(input int duty, input int eff, input int step);
        int d;
        d = eff - duty;
        if ((d <= step) && (d >= -step)) begin
            return eff;
        end else if (d > 0) begin
            return duty + step;
        end else begin
            return duty - step;
        end
    endfunction

endpackage

// File: rtl/pwm_slew_step.sv
// Combinational single-channel slew step, time-shared across channels
// by the sequencer.
module pwm_slew_step
    import pwm_ctrl_pkg::*;
#(
    parameter int DW   = 10,
    parameter int STEP = 8
) (
    input  logic signed [DW-1:0] duty,
    input  logic signed [DW-1:0] eff,
    output logic signed [DW-1:0] duty_next
);

    always_comb begin
        duty_next = DW'(slew(int'(duty), int'(eff), STEP));
    end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Per-channel target duty store with once-per-period slew of the applied
// duty; one channel is updated per clock after each generator tick.
module pwm_duty_sequencer
    import pwm_ctrl_pkg::*;
#(
    parameter int  DW   = 10,
    parameter int  NCH  = 4,
    parameter int  STEP = 8,
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 enable,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [CW-1:0]        wr_ch,
    input  logic signed [DW-1:0] wr_target,
    output logic signed [DW-1:0] duty_out [NCH],
    output logic [NCH-1:0]       settled,
    output logic                 busy,
    output logic                 overrun
);

    localparam logic signed [DW-1:0] MIN_DUTY = DW'(min_duty(DW));
    localparam logic [CW-1:0]        LAST_IDX = CW'(NCH - 1);

    logic signed [DW-1:0] duty_reg   [NCH];
    logic signed [DW-1:0] target_reg [NCH];

    state_t        state_reg, state_next;
    logic [CW-1:0] idx_reg, idx_next;
    logic          overrun_reg;
    logic          wr_accept;

    logic signed [DW-1:0] sel_duty;
    logic signed [DW-1:0] sel_eff;
    logic signed [DW-1:0] step_duty;

    assign wr_ready  = (state_reg == IDLE) && !rst;
    assign wr_accept = wr_valid && wr_ready;
    assign busy      = (state_reg == UPDATE);
    assign overrun   = overrun_reg;

    // enable is sampled on the channel's own processing cycle.
    assign sel_duty = duty_reg[idx_reg];
    assign sel_eff  = enable ? target_reg[idx_reg] : MIN_DUTY;

    pwm_slew_step #(
        .DW   (DW),
        .STEP (STEP)
    ) u_slew (
        .duty      (sel_duty),
        .eff       (sel_eff),
        .duty_next (step_duty)
    );

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE: begin
                if (tick) begin
                    state_next = UPDATE;
                    idx_next   = '0;
                end
            end
            UPDATE: begin
                if (idx_reg == LAST_IDX) begin
                    state_next = IDLE;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            if (tick && (state_reg == UPDATE)) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    // Writes to an index >= NCH match no channel and are dropped.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            always_ff @(posedge clk) begin
                if (rst) begin
                    target_reg[gi] <= MIN_DUTY;
                end else if (wr_accept && (int'(wr_ch) == gi)) begin
                    target_reg[gi] <= wr_target;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    duty_reg[gi] <= MIN_DUTY;
                end else if ((state_reg == UPDATE) && (int'(idx_reg) == gi)) begin
                    duty_reg[gi] <= step_duty;
                end
            end

            assign duty_out[gi] = duty_reg[gi];
            assign settled[gi]  = (duty_reg[gi] == (enable ? target_reg[gi] : MIN_DUTY));
        end
    endgenerate

endmodule
